// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control path:
// FSM states, the opcodes of the supported subset, and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Only beq (000) and bne (001) are implemented.
  function automatic logic branch_supported(input logic [2:0] f3);
    return (f3[2:1] == 2'b00);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RISC-V datapath: sequences each
// instruction, handles the memory req/ready handshake and counts retirements.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         result_src,
  output logic               illegal_instr,
  output logic [COUNT_W-1:0] instr_retired
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_supported(funct3) ? S_BRANCH : S_TRAP;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    result_src    = RES_ALUOUT;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        // PC+4 goes straight from the ALU to the PC in the completing cycle.
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRCA_PC;
          alu_src_b  = SRCB_FOUR;
          alu_op     = ALUOP_ADD;
          result_src = RES_ALU;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        // funct3[0] distinguishes bne from beq, inverting the taken sense.
        pc_write   = alu_zero ^ funct3[0];
      end
      S_TRAP:  illegal_instr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH: retire = 1'b1;
      S_MEMWRITE:                 retire = mem_ready;
      default:                    retire = 1'b0;
    endcase
    count_d = retire ? count_q + COUNT_W'(1) : count_q;
  end

  assign instr_retired = count_q;

endmodule
